ucsbece154b_bpred_ctrl: RTL

Controller for the fetch-stage branch predictor (BTB + gshare PHT + GHR) of the 5-stage RISC-V core. It carries each fetched instruction's prediction metadata down to Execute and compares it with the resolved outcome there. From that comparison it sequences the BTB and PHT update writes and raises the misprediction flush and redirect PC. It also keeps GHR reset sequencing and branch/mispredict performance counters. It sits between the hazard unit, the datapath E stage and `ucsbece154b_branch`.

---
 rtl/ucsbece154b_bpred_ctrl_pkg.sv | 7 +
 rtl/ucsbece154b_bpred_meta_pipe.sv | 51 +++++
 rtl/ucsbece154b_bpred_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/ucsbece154b_bpred_ctrl_pkg.sv
// ucsbece154b_bpred_ctrl_pkg: RISC-V control-transfer opcodes and branch-predictor controller FSM states
package ucsbece154b_bpred_ctrl_pkg;
  localparam logic [6:0] instr_branch_op = 7'b1100011;
  localparam logic [6:0] instr_jal_op = 7'b1101111;
  localparam logic [6:0] instr_jalr_op = 7'b1100111;
  typedef enum logic [1:0] {WARMUP = 2'd0, RUN = 2'd1, REDIRECT = 2'd2} state_t;
endpackage

// File: rtl/ucsbece154b_bpred_meta_pipe.sv
// ucsbece154b_bpred_meta_pipe: F->D->E prediction metadata registers (valid, taken, target, pht index, pc) with stall/flush
module ucsbece154b_bpred_meta_pipe
  import ucsbece154b_bpred_ctrl_pkg::*;
#(
  parameter int GW = 5
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          stall_f_i,
  input  logic          stall_d_i,
  input  logic          flush_d_i,
  input  logic          flush_e_i,
  input  logic          pred_taken_f_i,
  input  logic [31:0]   pred_target_f_i,
  input  logic [GW-1:0] pht_addr_f_i,
  input  logic [31:0]   pc_f_i,
  output logic          valid_e_o,
  output logic          pred_taken_e_o,
  output logic [31:0]   pred_target_e_o,
  output logic [GW-1:0] pht_addr_e_o,
  output logic [31:0]   pc_e_o
);
  typedef struct packed {
    logic          valid;
    logic          taken;
    logic [31:0]   target;
    logic [GW-1:0] pht;
    logic [31:0]   pc;
  } meta_t;
  meta_t d_q, d_d, e_q, e_d;
  always_comb begin
    d_d = stall_d_i ? d_q : meta_t'({!stall_f_i, pred_taken_f_i, pred_target_f_i, pht_addr_f_i, pc_f_i});
    d_d.valid = d_d.valid & !flush_d_i;
    e_d = d_q;
    e_d.valid = d_q.valid & !flush_e_i;
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      d_q <= '0;
      e_q <= '0;
    end else begin
      d_q <= d_d;
      e_q <= e_d;
    end
  end
  assign valid_e_o = e_q.valid;
  assign pred_taken_e_o = e_q.taken;
  assign pred_target_e_o = e_q.target;
  assign pht_addr_e_o = e_q.pht;
  assign pc_e_o = e_q.pc;
endmodule

// File: rtl/ucsbece154b_bpred_ctrl.sv
// ucsbece154b_bpred_ctrl: resolves E-stage predictions, drives BTB/PHT writes, mispredict flush/redirect, GHR reset and perf counters
module ucsbece154b_bpred_ctrl
  import ucsbece154b_bpred_ctrl_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS = 5
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic                               StallF_i,
  input  logic                               StallD_i,
  input  logic                               FlushD_i,
  input  logic                               FlushE_i,
  input  logic [31:0]                        PCF_i,
  input  logic                               BranchTakenF_i,
  input  logic [31:0]                        BTBtargetF_i,
  input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
  input  logic [6:0]                         opE_i,
  input  logic                               BranchCondE_i,
  input  logic [31:0]                        PCTargetE_i,
  input  logic [31:0]                        PCPlus4E_i,
  output logic                               BTBwe_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
  output logic [31:0]                        BTBwritedata_o,
  output logic                               PHTwe_o,
  output logic                               PHTincrement_o,
  output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
  output logic                               GHRreset_o,
  output logic                               MispredictE_o,
  output logic [31:0]                        RedirectPC_o,
  output logic [31:0]                        BranchCount_o,
  output logic [31:0]                        MispredictCount_o
);
  localparam int BI = $clog2(NUM_BTB_ENTRIES);
  logic valid_e, pred_taken_e, run, is_b, is_j, actual_taken, tgt_mis;
  logic [31:0] pred_target_e, pc_e;
  logic [NUM_GHR_BITS-1:0] pht_addr_e;
  logic [31:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  state_t state_q, state_d;
  logic unused_pc;
  assign unused_pc = ^{pc_e[31:BI+2], pc_e[1:0]};
  ucsbece154b_bpred_meta_pipe #(.GW(NUM_GHR_BITS)) u_meta (
    .clk(clk),
    .reset_i(reset_i),
    .stall_f_i(StallF_i),
    .stall_d_i(StallD_i),
    .flush_d_i(FlushD_i | MispredictE_o),
    .flush_e_i(FlushE_i | MispredictE_o),
    .pred_taken_f_i(BranchTakenF_i),
    .pred_target_f_i(BTBtargetF_i),
    .pht_addr_f_i(PHTreadaddressF_i),
    .pc_f_i(PCF_i),
    .valid_e_o(valid_e),
    .pred_taken_e_o(pred_taken_e),
    .pred_target_e_o(pred_target_e),
    .pht_addr_e_o(pht_addr_e),
    .pc_e_o(pc_e)
  );
  // Only RUN may resolve: WARMUP and the post-mispredict REDIRECT cycle see nothing in E.
  always_comb begin
    run = state_q == RUN;
    is_b = run & valid_e & (opE_i == instr_branch_op);
    is_j = run & valid_e & (opE_i == instr_jal_op | opE_i == instr_jalr_op);
    tgt_mis = pred_target_e != PCTargetE_i;
    actual_taken = is_j | (is_b & BranchCondE_i);
    MispredictE_o = (is_b | is_j) & ((pred_taken_e != actual_taken) | (actual_taken & tgt_mis));
    RedirectPC_o = MispredictE_o ? (actual_taken ? PCTargetE_i : PCPlus4E_i) : '0;
    BTBwe_o = actual_taken & (!pred_taken_e | tgt_mis);
    BTBwriteaddress_o = BTBwe_o ? pc_e[BI+1:2] : '0;
    BTBwritedata_o = BTBwe_o ? PCTargetE_i : '0;
    PHTwe_o = is_b;
    PHTincrement_o = is_b & BranchCondE_i;
    PHTwriteaddress_o = is_b ? pht_addr_e : '0;
    GHRreset_o = state_q == WARMUP;
    state_d = MispredictE_o ? REDIRECT : RUN;
    branch_count_d = branch_count_q + {31'd0, is_b | is_j};
    mispredict_count_d = mispredict_count_q + {31'd0, MispredictE_o};
  end
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= WARMUP;
      branch_count_q <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q <= state_d;
      branch_count_q <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
  assign BranchCount_o = branch_count_q;
  assign MispredictCount_o = mispredict_count_q;
endmodule
